mem_bus_initiator: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mbi_timeout_ctr.sv | 33 +++
 rtl/mem_bus_initiator.sv | 96 +++++++++
 tb/tb_mem_bus_initiator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory handshake bus initiator.
package mem_bus_pkg;

   localparam int MBI_AW      = 16;
   localparam int MBI_DW      = 16;
   localparam int MBI_TIMEOUT = 255;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ASSERT,
      RELEASE,
      DONE
   } mbi_state_t;

   // Counter must be able to hold TIMEOUT itself so it can saturate there.
   function automatic int ctr_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mbi_timeout_ctr.sv
// Bus-occupancy counter: cleared when a transaction is accepted, counts while the bus is held,
// flags expiry from the TIMEOUT-1 count onward and saturates so it can never wrap back to zero.
module mbi_timeout_ctr
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT = MBI_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = ctr_width(TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && cnt != SAT) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = enable && (cnt >= LIMIT);

endmodule

// File: rtl/mem_bus_initiator.sv
// CPU-side initiator: runs one four-phase rdM/wrM-mfc handshake per accepted request, then
// pulses done (err=1 on timeout). Every output is registered; mfc only steers next-state.
module mem_bus_initiator
   import mem_bus_pkg::*;
#(
   parameter int AW      = MBI_AW,
   parameter int DW      = MBI_DW,
   parameter int TIMEOUT = MBI_TIMEOUT
) (
   input  logic          clk,
   input  logic          rstIn,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] Abus,
   inout  wire  [DW-1:0] Dbus,
   output logic          rdM,
   output logic          wrM,
   input  logic          mfc
);

   mbi_state_t    state;
   mbi_state_t    next_state;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic          expired;
   logic          timeout;
   logic          accept;
   logic          bus_held;
   logic          drive_en;

   assign accept   = (state == IDLE) && req;
   assign bus_held = (state == SETUP) || (state == ASSERT) || (state == RELEASE);
   assign drive_en = we_q && bus_held;
   assign Dbus     = drive_en ? wdata_q : {DW{1'bz}};

   mbi_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst_n   (rstIn),
      .clear   (accept),
      .enable  (bus_held),
      .expired (expired)
   );

   // A met exit condition always takes priority over expiry, so a late mfc still completes cleanly.
   always_comb begin
      next_state = state;
      timeout    = 1'b0;
      case (state)
         IDLE:    if (req) next_state = SETUP;
         SETUP:   if (!mfc) next_state = ASSERT;
                  else if (expired) begin next_state = DONE; timeout = 1'b1; end
         ASSERT:  if (mfc) next_state = RELEASE;
                  else if (expired) begin next_state = DONE; timeout = 1'b1; end
         RELEASE: if (!mfc) next_state = DONE;
                  else if (expired) begin next_state = DONE; timeout = 1'b1; end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstIn) begin
      if (!rstIn) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         Abus    <= '0;
         rdM     <= 1'b0;
         wrM     <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
         done  <= (next_state == DONE);
         rdM   <= (next_state == ASSERT) && !we_q;
         wrM   <= (next_state == ASSERT) && we_q;
         if (accept) begin
            we_q    <= we;
            Abus    <= addr;
            wdata_q <= wdata;
            err     <= 1'b0;
         end
         if (next_state == DONE) err <= timeout;
         if (state == ASSERT && mfc && !we_q) rdata <= Dbus;
      end
   end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator (TIMEOUT=8); the bench plays the memory responder.
module tb_mem_bus_initiator;

   logic        clk;
   logic        rstIn;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] rdata;
   logic [15:0] Abus;
   logic        rdM;
   logic        wrM;
   logic        mfc;
   logic        resp_oe;
   logic [15:0] resp_dat;
   wire  [15:0] Dbus;

   int checks;
   int failures;

   // Responder side of the shared bus; driving 0 while the initiator should be off exposes stray drive.
   assign Dbus = resp_oe ? resp_dat : 16'hzzzz;

   mem_bus_initiator #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
      .clk   (clk),
      .rstIn (rstIn),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .rdata (rdata),
      .Abus  (Abus),
      .Dbus  (Dbus),
      .rdM   (rdM),
      .wrM   (wrM),
      .mfc   (mfc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Issues one read and plays a responder that answers after `waits` strobe cycles.
   // Returns at the done cycle or after maxcyc cycles, whichever comes first.
   task automatic run_read(input logic [15:0] a, input logic [15:0] val, input int waits,
                           input int stale, input int extra_req, input int maxcyc,
                           output int rd_hi, output int wr_hi, output int first_rd,
                           output int done_cyc, output logic err_d, output int dbus_bad);
      int strobe_cnt;
      int stale_left;
      rd_hi = 0; wr_hi = 0; first_rd = -1; done_cyc = -1; err_d = 1'b1; dbus_bad = 0;
      strobe_cnt = 0; stale_left = stale;
      resp_oe = 1'b1; resp_dat = 16'h0000; mfc = (stale > 0);
      req = 1'b1; we = 1'b0; addr = a; wdata = 16'h5A5A;
      step();
      req = 1'b0; addr = 16'hFFFF;
      for (int c = 1; c <= maxcyc; c++) begin
         if (Dbus !== resp_dat) dbus_bad++;
         if (rdM) begin rd_hi++; if (first_rd < 0) first_rd = c; end
         if (wrM) wr_hi++;
         if (done) begin done_cyc = c; err_d = err; break; end
         if (c == extra_req) begin req = 1'b1; addr = 16'h0200; end
         else req = 1'b0;
         if (stale_left > 0) begin
            stale_left--;
            mfc = (stale_left > 0);
         end else if (rdM) begin
            strobe_cnt++;
            mfc = (strobe_cnt > waits);
         end else begin
            mfc = 1'b0;
         end
         resp_dat = (mfc && stale_left == 0) ? val : 16'h0000;
         step();
      end
      req = 1'b0; mfc = 1'b0; resp_dat = 16'h0000;
   endtask

   task automatic test_reset();
      rstIn = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
      mfc = 1'b0; resp_oe = 1'b1; resp_dat = 16'h0000;
      step(); step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err); end
      checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
      checks++; if (Abus !== 16'h0) begin failures++; $display("FAIL reset_abus got=%h exp=0000", Abus); end
      checks++; if (rdM !== 1'b0 || wrM !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", rdM, wrM); end
      checks++; if (Dbus !== 16'h0) begin failures++; $display("FAIL reset_dbus got=%h exp=0000", Dbus); end
      rstIn = 1'b1;
      step();
   endtask

   task automatic test_write();
      checks++; if (Dbus !== 16'h0) begin failures++; $display("FAIL wr_idle_dbus got=%h exp=0000", Dbus); end
      req = 1'b1; we = 1'b1; addr = 16'h00A0; wdata = 16'h1234;
      step();                                    // SETUP
      req = 1'b0; wdata = 16'hFFFF; addr = 16'h0; resp_oe = 1'b0;
      #1;
      checks++; if (Dbus !== 16'h1234) begin failures++; $display("FAIL wr_setup_dbus got=%h exp=1234", Dbus); end
      checks++; if (busy !== 1'b1 || wrM !== 1'b0 || rdM !== 1'b0) begin failures++; $display("FAIL wr_setup_ctl got=busy%b wr%b rd%b exp=busy1 wr0 rd0", busy, wrM, rdM); end
      checks++; if (Abus !== 16'h00A0) begin failures++; $display("FAIL wr_setup_abus got=%h exp=00a0", Abus); end
      step();                                    // ASSERT
      checks++; if (wrM !== 1'b1 || rdM !== 1'b0) begin failures++; $display("FAIL wr_assert_strobes got=wr%b rd%b exp=wr1 rd0", wrM, rdM); end
      checks++; if (Dbus !== 16'h1234) begin failures++; $display("FAIL wr_assert_dbus got=%h exp=1234", Dbus); end
      mfc = 1'b1;
      step();                                    // RELEASE
      checks++; if (wrM !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL wr_release_ctl got=wr%b done%b exp=wr0 done0", wrM, done); end
      checks++; if (Dbus !== 16'h1234 || Abus !== 16'h00A0) begin failures++; $display("FAIL wr_release_hold got=%h/%h exp=1234/00a0", Dbus, Abus); end
      mfc = 1'b0;
      step();                                    // DONE, four cycles after the req cycle
      resp_oe = 1'b1; resp_dat = 16'h0000;
      #1;
      checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL wr_done got=done%b err%b exp=done1 err0", done, err); end
      checks++; if (Dbus !== 16'h0000) begin failures++; $display("FAIL wr_done_dbus got=%h exp=0000", Dbus); end
      checks++; if (Abus !== 16'h00A0) begin failures++; $display("FAIL wr_done_abus got=%h exp=00a0", Abus); end
      step();                                    // IDLE
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL wr_idle got=done%b busy%b exp=0 0", done, busy); end
   endtask

   task automatic test_read_wait();
      int rd_hi, wr_hi, first_rd, done_cyc, dbus_bad;
      logic err_d;
      run_read(16'h0040, 16'hBEEF, 3, 0, 0, 20, rd_hi, wr_hi, first_rd, done_cyc, err_d, dbus_bad);
      checks++; if (rd_hi !== 4) begin failures++; $display("FAIL rd_rdm_cycles got=%0d exp=4", rd_hi); end
      checks++; if (wr_hi !== 0) begin failures++; $display("FAIL rd_wrm_cycles got=%0d exp=0", wr_hi); end
      checks++; if (first_rd !== 2) begin failures++; $display("FAIL rd_first_strobe got=%0d exp=2", first_rd); end
      checks++; if (done_cyc !== 7 || err_d !== 1'b0) begin failures++; $display("FAIL rd_done got=cyc%0d err%b exp=cyc7 err0", done_cyc, err_d); end
      checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=beef", rdata); end
      checks++; if (dbus_bad !== 0) begin failures++; $display("FAIL rd_dbus_driven got=%0d exp=0", dbus_bad); end
      checks++; if (Abus !== 16'h0040) begin failures++; $display("FAIL rd_abus got=%h exp=0040", Abus); end
      step();
   endtask

   task automatic test_stale_mfc();
      int rd_hi, wr_hi, first_rd, done_cyc, dbus_bad;
      logic err_d;
      run_read(16'h0060, 16'h1357, 0, 5, 0, 20, rd_hi, wr_hi, first_rd, done_cyc, err_d, dbus_bad);
      checks++; if (first_rd !== 6) begin failures++; $display("FAIL stale_first_strobe got=%0d exp=6", first_rd); end
      checks++; if (rd_hi !== 1) begin failures++; $display("FAIL stale_rdm_cycles got=%0d exp=1", rd_hi); end
      checks++; if (done_cyc !== 8 || err_d !== 1'b0) begin failures++; $display("FAIL stale_done got=cyc%0d err%b exp=cyc8 err0", done_cyc, err_d); end
      checks++; if (rdata !== 16'h1357) begin failures++; $display("FAIL stale_rdata got=%h exp=1357", rdata); end
      step();
   endtask

   task automatic test_timeout();
      int rd_hi, wr_hi, first_rd, done_cyc, dbus_bad;
      logic err_d;
      run_read(16'h0050, 16'hDEAD, 1000, 0, 0, 20, rd_hi, wr_hi, first_rd, done_cyc, err_d, dbus_bad);
      checks++; if (rd_hi !== 7) begin failures++; $display("FAIL to_rdm_cycles got=%0d exp=7", rd_hi); end
      checks++; if (done_cyc !== 9 || err_d !== 1'b1) begin failures++; $display("FAIL to_done got=cyc%0d err%b exp=cyc9 err1", done_cyc, err_d); end
      checks++; if (rdM !== 1'b0) begin failures++; $display("FAIL to_strobe_low got=%b exp=0", rdM); end
      checks++; if (rdata !== 16'h1357) begin failures++; $display("FAIL to_rdata_kept got=%h exp=1357", rdata); end
      step();
      run_read(16'h0054, 16'hC0DE, 0, 0, 0, 20, rd_hi, wr_hi, first_rd, done_cyc, err_d, dbus_bad);
      checks++; if (done_cyc !== 4 || err_d !== 1'b0) begin failures++; $display("FAIL to_recover_done got=cyc%0d err%b exp=cyc4 err0", done_cyc, err_d); end
      checks++; if (rdata !== 16'hC0DE) begin failures++; $display("FAIL to_recover_rdata got=%h exp=c0de", rdata); end
      step();
   endtask

   task automatic test_back_to_back();
      int rd_hi, wr_hi, first_rd, done_cyc, dbus_bad, busy_hi;
      logic err_d;
      run_read(16'h0100, 16'h2468, 2, 0, 3, 20, rd_hi, wr_hi, first_rd, done_cyc, err_d, dbus_bad);
      checks++; if (done_cyc !== 6 || rd_hi !== 3) begin failures++; $display("FAIL b2b_first got=cyc%0d rd%0d exp=cyc6 rd3", done_cyc, rd_hi); end
      checks++; if (Abus !== 16'h0100 || rdata !== 16'h2468) begin failures++; $display("FAIL b2b_first_data got=%h/%h exp=0100/2468", Abus, rdata); end
      step();                                    // IDLE cycle right after DONE
      run_read(16'h0300, 16'h3579, 0, 0, 0, 20, rd_hi, wr_hi, first_rd, done_cyc, err_d, dbus_bad);
      checks++; if (done_cyc !== 4 || err_d !== 1'b0) begin failures++; $display("FAIL b2b_second got=cyc%0d err%b exp=cyc4 err0", done_cyc, err_d); end
      checks++; if (Abus !== 16'h0300 || rdata !== 16'h3579) begin failures++; $display("FAIL b2b_second_data got=%h/%h exp=0300/3579", Abus, rdata); end
      busy_hi = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (busy || rdM) busy_hi++;
      end
      checks++; if (busy_hi !== 0) begin failures++; $display("FAIL b2b_no_extra_txn got=%0d exp=0", busy_hi); end
   endtask

   task automatic test_reset_mid_assert();
      int done_hi, rd_hi, wr_hi, first_rd, done_cyc, dbus_bad;
      logic err_d;
      req = 1'b1; we = 1'b1; addr = 16'h00B0; wdata = 16'hCAFE;
      step();                                    // SETUP
      req = 1'b0; resp_oe = 1'b0;
      step();                                    // ASSERT
      checks++; if (wrM !== 1'b1 || Dbus !== 16'hCAFE) begin failures++; $display("FAIL rst_pre got=wr%b dbus%h exp=wr1 dbus cafe", wrM, Dbus); end
      #1 rstIn = 1'b0;
      #1;
      checks++; if (wrM !== 1'b0 || rdM !== 1'b0) begin failures++; $display("FAIL rst_async_strobes got=%b%b exp=00", rdM, wrM); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_async_ctl got=%b%b%b exp=000", busy, done, err); end
      checks++; if (Abus !== 16'h0 || rdata !== 16'h0) begin failures++; $display("FAIL rst_async_regs got=%h/%h exp=0000/0000", Abus, rdata); end
      resp_oe = 1'b1; resp_dat = 16'h0000;
      #1;
      checks++; if (Dbus !== 16'h0000) begin failures++; $display("FAIL rst_async_dbus got=%h exp=0000", Dbus); end
      done_hi = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) done_hi++;
      end
      rstIn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         if (done) done_hi++;
      end
      checks++; if (done_hi !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_hi); end
      run_read(16'h0070, 16'h7777, 0, 0, 0, 20, rd_hi, wr_hi, first_rd, done_cyc, err_d, dbus_bad);
      checks++; if (done_cyc !== 4 || err_d !== 1'b0 || rdata !== 16'h7777) begin failures++; $display("FAIL rst_clean_read got=cyc%0d err%b rdata%h exp=cyc4 err0 rdata7777", done_cyc, err_d, rdata); end
      step();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_write();
      test_read_wait();
      test_stale_mfc();
      test_timeout();
      test_back_to_back();
      test_reset_mid_assert();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
